display_corriente: RTL and testbench
====================================

// Module: display_corriente
// PURPOSE
//   Consumer end of the current-selection path: samples the 7-bit current setpoint I,
//   converts it to 3 BCD digits with a sequential shift-add-3 (double-dabble) engine,
//   and drives a time-multiplexed, active-low 7-segment display (3 digits used, an[3] off).
//   Sits between Seleccion_Corriente and the board display pins.
// PARAMETERS
//   VAL_W       7       width of input value I
//   REFRESH_DIV 100000  clk cycles per digit slot (100 MHz -> 1 kHz per digit)
//   CNT_W       17      width of refresh counter, >= clog2(REFRESH_DIV)
// PORTS
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous reset, active-high
//   ENi    in   1      enable; 0 = hold current conversion result, keep scanning
//   I      in   VAL_W  current setpoint, 0..127 (nominal 0..100)
//   bcd    out  12     {hundreds,tens,units}, registered conversion result
//   busy   out  1      1 while a conversion is in progress
//   seg    out  7      segments {g,f,e,d,c,b,a}, active-low
//   an     out  4      digit anodes, active-low one-hot; an[3] always 1
// BEHAVIOUR
//   Reset (async, rst=1): bcd=0, busy=0, seg=7'h7F, an=4'hF, FSM=IDLE, scan idx=0,
//     refresh cnt=0, captured value=0, valid flag=0.
//   FSM IDLE -> SHIFT when ENi=1 and (valid=0 or I != captured): load captured=I, shift reg;
//     busy=1 from this edge.
//   SHIFT: one double-dabble iteration per cycle (add 3 to each nibble >=5, then shift left);
//     exactly VAL_W(=7) cycles, iteration counter 0..VAL_W-1; then -> DONE.
//   DONE: bcd <= result, valid=1, busy=0; -> IDLE. Total: bcd updated 8 edges after the
//     capturing edge.
//   I changing during SHIFT/DONE is ignored; the newer value is picked up in the IDLE cycle
//     after DONE (no lost final value).
//   ENi=0: no new conversion starts; an in-flight conversion completes.
//   Scan: refresh cnt counts 0..REFRESH_DIV-1, wraps; on wrap idx advances 0->1->2->0.
//     idx 0: units, an=4'b1110; idx 1: tens, an=4'b1101; idx 2: hundreds, an=4'b1011.
//   seg/an registered, updated on same edge as idx; first digit shown 1 cycle after reset release.
//   Decode 0..9 standard; nibble codes 10..15 unreachable, map to blank (7'h7F).
//   Scan runs continuously, independent of ENi and busy; bcd changes take effect at next slot.
//   rst mid-conversion: abort, return to reset state, reconvert after release (valid=0).
// CONFIGURATION
//   LZ_BLANK_EN defined: leading zeros blanked (hundreds blank if 0; tens blank if hundreds=0
//     and tens=0); units always shown; an still asserted, seg=7'h7F for blanked digit.
//   LZ_BLANK_EN undefined: all three digits always shown, e.g. I=5 -> "005".
// STRUCTURE
//   Shared package/include: FSM state encodings (IDLE/SHIFT/DONE), SEG_BLANK=7'h7F,
//     7-seg digit table, ANODE_OFF=4'hF.
//   One sub-module: bin2bcd_seq (FSM + double-dabble, ports clk,rst,start,bin,bcd,busy);
//     scan counter, digit mux and segment decode stay in top.
// TESTING (use REFRESH_DIV=4)
//   rst=1 for 3 cycles -> seg=7'h7F, an=4'hF, bcd=0, busy=0 throughout.
//   Release rst, ENi=1, I=100 -> busy rises next edge, bcd=12'h100 8 edges later; slots show
//     0,0,1 (units,tens,hundreds); seg for '1' = 7'b1111001.
//   I=42 then I=7 two cycles later (mid-SHIFT) -> bcd passes 12'h042, then 12'h007; no other value.
//   ENi=0, I=99 -> bcd holds, busy stays 0; ENi=1 -> bcd=12'h099 after 8 more edges.
//   Scan: check an sequence 1110,1101,1011,1110 changing every 4 cycles; an[3]=1 always.
//   LZ_BLANK_EN, I=7 -> hundreds and tens slots seg=7'h7F, units 7'b1111000; rst pulsed mid-SHIFT
//     -> all outputs at reset values immediately, reconversion after release.

Source files
------------

// File: rtl/display_corriente_pkg.sv
// Shared types and constants for the current-setpoint display path:
// converter FSM states, segment/anode constants and the 7-segment digit table.
package display_corriente_pkg;

  localparam int unsigned BCD_W = 12;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [AN_W-1:0]  ANODE_OFF = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Active-low segments {g,f,e,d,c,b,a}; codes 10..15 are unreachable and shown blank
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Active-low one-hot anode for scan slot; an[3] is never driven low
  function automatic logic [AN_W-1:0] anode_sel(input logic [1:0] idx);
    logic [AN_W-1:0] a;
    case (idx)
      2'd0:    a = 4'b1110;
      2'd1:    a = 4'b1101;
      2'd2:    a = 4'b1011;
      default: a = ANODE_OFF;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 iteration per clock,
// VAL_W iterations per conversion, result registered in the DONE state.
module bin2bcd_seq
  import display_corriente_pkg::*;
#(
  parameter int unsigned VAL_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             busy
);

  localparam int unsigned SR_W   = BCD_W + VAL_W;
  localparam int unsigned ITER_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

  conv_state_t       state, state_d;
  logic [SR_W-1:0]   sr, sr_d, sr_adj;
  logic [ITER_W-1:0] iter, iter_d;
  logic [BCD_W-1:0]  bcd_d;
  logic              busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sr    <= '0;
      iter  <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      sr    <= sr_d;
      iter  <= iter_d;
      bcd   <= bcd_d;
      busy  <= busy_d;
    end
  end

  // Next state; busy is high exactly while the FSM sits in SHIFT or DONE
  always_comb begin
    state_d = state;
    sr_d    = sr;
    iter_d  = iter;
    bcd_d   = bcd;
    busy_d  = busy;
    sr_adj  = sr;
    for (int k = 0; k < 3; k++) begin
      if (sr[VAL_W + 4*k +: 4] >= 4'd5)
        sr_adj[VAL_W + 4*k +: 4] = sr[VAL_W + 4*k +: 4] + 4'd3;
    end
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          sr_d    = {BCD_W'(0), bin};
          iter_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        sr_d   = {sr_adj[SR_W-2:0], 1'b0};
        iter_d = iter + ITER_W'(1);
        if (iter == ITER_W'(VAL_W - 1))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        bcd_d   = sr[SR_W-1 -: BCD_W];
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/display_corriente.sv
// Current-setpoint display: converts I to BCD and scans 3 active-low 7-seg digits.
// Build option: define LZ_BLANK_EN to blank leading zeros of hundreds/tens.
module display_corriente
  import display_corriente_pkg::*;
#(
  parameter int unsigned VAL_W       = 7,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ENi,
  input  logic [VAL_W-1:0] I,
  output logic [BCD_W-1:0] bcd,
  output logic             busy,
  output logic [SEG_W-1:0] seg,
  output logic [AN_W-1:0]  an
);

  logic [VAL_W-1:0] captured;
  logic             valid;
  logic             start_c;

  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       idx, idx_d;
  logic             live;
  logic             wrap_c;
  logic [3:0]       digit_c;
  logic             blank_c;
  logic [SEG_W-1:0] seg_d;

  // New conversion only from idle, and only when the value is new or none is held yet
  assign start_c = ENi & ~busy & (~valid | (I != captured));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      captured <= '0;
      valid    <= 1'b0;
    end else if (start_c) begin
      captured <= I;
      valid    <= 1'b1;
    end
  end

  bin2bcd_seq #(.VAL_W(VAL_W)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start_c),
    .bin   (I),
    .bcd   (bcd),
    .busy  (busy)
  );

  // Scan counter and slot selection for the slot being loaded this edge
  always_comb begin
    wrap_c = (cnt == CNT_W'(REFRESH_DIV - 1));
    cnt_d  = wrap_c ? '0 : cnt + CNT_W'(1);
    idx_d  = idx;
    if (wrap_c)
      idx_d = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    case (idx_d)
      2'd1:    digit_c = bcd[7:4];
      2'd2:    digit_c = bcd[11:8];
      default: digit_c = bcd[3:0];
    endcase
`ifdef LZ_BLANK_EN
    blank_c = ((idx_d == 2'd2) && (bcd[11:8] == 4'd0)) ||
              ((idx_d == 2'd1) && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0));
`else
    blank_c = 1'b0;
`endif
    seg_d = blank_c ? SEG_BLANK : seg_decode(digit_c);
  end

  // seg/an reload on each slot change, plus once right after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= 2'd0;
      live <= 1'b0;
      seg  <= SEG_BLANK;
      an   <= ANODE_OFF;
    end else begin
      cnt  <= cnt_d;
      idx  <= idx_d;
      live <= 1'b1;
      if (wrap_c || !live) begin
        seg <= seg_d;
        an  <= anode_sel(idx_d);
      end
    end
  end

endmodule

// File: tb/tb_display_corriente.sv
// Scoreboard bench for display_corriente (REFRESH_DIV=4): expected conversions are
// queued by the stimulus and checked by a monitor on busy edges.
module tb_display_corriente;

  logic        clk = 1'b0;
  logic        rst;
  logic        ENi;
  logic [6:0]  I;
  logic [11:0] bcd;
  logic        busy;
  logic [6:0]  seg;
  logic [3:0]  an;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [11:0] bcd;
    int          start;
    int          done;
  } exp_t;
  exp_t exp_q[$];

  display_corriente #(.VAL_W(7), .REFRESH_DIV(4), .CNT_W(17)) dut (
    .clk  (clk),
    .rst  (rst),
    .ENi  (ENi),
    .I    (I),
    .bcd  (bcd),
    .busy (busy),
    .seg  (seg),
    .an   (an)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] b, input logic [3:0] a);
    case (a)
      4'b1110: return seg_of(b[3:0]);
`ifdef LZ_BLANK_EN
      4'b1101: return (b[11:8] == 4'd0 && b[7:4] == 4'd0) ? 7'h7F : seg_of(b[7:4]);
      4'b1011: return (b[11:8] == 4'd0) ? 7'h7F : seg_of(b[11:8]);
`else
      4'b1101: return seg_of(b[7:4]);
      4'b1011: return seg_of(b[11:8]);
`endif
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [3:0] rot(input logic [3:0] a);
    case (a)
      4'b1110: return 4'b1101;
      4'b1101: return 4'b1011;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int v, input int s);
    exp_t e;
    e.bcd   = to_bcd(v);
    e.start = s;
    e.done  = s + 8;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 32'(n < 60), 32'd1);
  endtask

  // Walk four slot changes: rotation order, 4-cycle period, decoded segments
  task automatic scan_check(input logic [11:0] b);
    logic [3:0] prev, nxt;
    int n;
    prev = an;
    n = 0;
    while (an === prev && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("scan_first_change", 32'(n < 10), 32'd1);
    check("scan_first_code",
          32'(an == 4'b1110 || an == 4'b1101 || an == 4'b1011), 32'd1);
    nxt = rot(an);
    for (int i = 0; i < 4; i++) begin
      check("scan_seg", 32'(seg), 32'(exp_seg(b, an)));
      prev = an;
      n = 0;
      while (an === prev && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("scan_period", 32'(n), 32'd4);
      check("scan_an_order", 32'(an), 32'(nxt));
      nxt = rot(an);
    end
  endtask

  // Monitor: busy rise must match queued start, busy fall must deliver queued bcd
  logic        busy_q = 1'b0;
  logic [11:0] bcd_q  = '0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      busy_q = 1'b0;
      bcd_q  = '0;
    end else begin
      if (an[3] !== 1'b1) begin
        checks++; failures++;
        $display("FAIL an3_high: got %b expected 1", an[3]);
      end
      if (busy && !busy_q) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL busy_rise: got unexpected conversion at cycle %0d, expected none", cyc);
        end else if (cyc != exp_q[0].start) begin
          failures++;
          $display("FAIL busy_rise_cycle: got %0d expected %0d", cyc, exp_q[0].start);
        end
      end
      if (!busy && busy_q) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bcd_done: got %h with no expected result", bcd);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (bcd !== e.bcd) begin
            failures++;
            $display("FAIL bcd_value: got %h expected %h", bcd, e.bcd);
          end
          checks++;
          if (cyc != e.done) begin
            failures++;
            $display("FAIL bcd_latency: got cycle %0d expected %0d", cyc, e.done);
          end
        end
      end else if (bcd !== bcd_q) begin
        checks++; failures++;
        $display("FAIL bcd_spurious: got %h expected %h", bcd, bcd_q);
      end
      busy_q = busy;
      bcd_q  = bcd;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ENi = 1'b0;
    I   = '0;
    repeat (3) begin
      @(negedge clk);
      check("rst_seg",  32'(seg),  32'h7F);
      check("rst_an",   32'(an),   32'hF);
      check("rst_bcd",  32'(bcd),  32'h0);
      check("rst_busy", 32'(busy), 32'h0);
    end

    // Release, request 100
    rst = 1'b0;
    ENi = 1'b1;
    I   = 7'd100;
    push_exp(100, cyc + 1);
    @(negedge clk);
    check("first_slot_an",  32'(an),  32'b1110);
    check("first_slot_seg", 32'(seg), 32'h40);
    wait_idle();
    check("bcd_100", 32'(bcd), 32'h100);
    scan_check(12'h100);

    // 42 then 7 while the first is still shifting
    I = 7'd42;
    push_exp(42, cyc + 1);
    push_exp(7, cyc + 10);
    @(negedge clk);
    @(negedge clk);
    I = 7'd7;
    wait_idle();
    check("bcd_007", 32'(bcd), 32'h007);

    // Disabled: no conversion starts
    ENi = 1'b0;
    I   = 7'd99;
    repeat (20) @(negedge clk);
    check("hold_bcd",  32'(bcd),  32'h007);
    check("hold_busy", 32'(busy), 32'h0);
    ENi = 1'b1;
    push_exp(99, cyc + 1);
    wait_idle();
    check("bcd_099", 32'(bcd), 32'h099);
    scan_check(12'h099);

    // Reset in the middle of a conversion
    I = 7'd55;
    push_exp(55, cyc + 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_seg",  32'(seg),  32'h7F);
    check("midrst_an",   32'(an),   32'hF);
    check("midrst_bcd",  32'(bcd),  32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_exp(55, cyc + 1);
    wait_idle();
    check("bcd_055", 32'(bcd), 32'h055);

    // Small value exercises leading digits
    I = 7'd7;
    push_exp(7, cyc + 1);
    wait_idle();
    scan_check(12'h007);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
